// File: rtl/ppu_scanline_buffer_if.sv
// Bus between the PPU pixel stream, the scanline buffer and the scaler.
//
// Handshake semantics: pix_valid qualifies pix_x/pix_y/pix_data for exactly
// one cycle and is never back-pressured. line_ready stays high while the read
// bank holds a complete line. A one-cycle line_ack pulse while line_ready is
// high releases that bank. rd_req in cycle N returns rd_data with rd_valid in
// cycle N+1; reads are never stalled.
interface ppu_scanline_buffer_if #(
    parameter int XW    = 9,
    parameter int PIX_W = 8
);
    logic             pix_valid;
    logic [XW-1:0]    pix_x;
    logic [XW-1:0]    pix_y;
    logic [PIX_W-1:0] pix_data;
    logic             line_ready;
    logic [XW-1:0]    line_y;
    logic             line_ack;
    logic             rd_req;
    logic [XW-1:0]    rd_x;
    logic [PIX_W-1:0] rd_data;
    logic             rd_valid;
    logic             overflow;

    // Pixel source and scaler side
    modport master (
        output pix_valid, pix_x, pix_y, pix_data, line_ack, rd_req, rd_x,
        input  line_ready, line_y, rd_data, rd_valid, overflow
    );

    // Scanline buffer side
    modport slave (
        input  pix_valid, pix_x, pix_y, pix_data, line_ack, rd_req, rd_x,
        output line_ready, line_y, rd_data, rd_valid, overflow
    );
endinterface

// File: rtl/ppu_scanline_buffer.sv
// Ping-pong scanline buffer: captures one PPU line into the write bank while
// the scaler reads the previously completed line from the other bank.
module ppu_scanline_buffer #(
    parameter int LINE_W = 256,
    parameter int PIX_W  = 8,
    parameter int XW     = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    ppu_scanline_buffer_if.slave   bus,
    output logic                   dbg_held_o
);
    localparam int AW = $clog2(LINE_W);

    typedef enum logic {
        FREE = 1'b0,
        HELD = 1'b1
    } rb_state_e;

    rb_state_e        state_q, state_d;
    logic             wbank_q, wbank_d;
    logic [XW-1:0]    line_y_q, line_y_d;
    logic [XW-1:0]    cap_y_q, cap_y_d;
    logic             overflow_q, overflow_d;
    logic [PIX_W-1:0] rd_data_q;
    logic             rd_valid_q;

    // Bank 0 occupies addresses 0..LINE_W-1, bank 1 the upper half.
    logic [PIX_W-1:0] mem_q [0:2*LINE_W-1];

    logic          wr_en;
    logic          line_done;
    logic [AW:0]   wr_addr;
    logic          rd_in_range;
    logic [AW:0]   rd_addr;

    assign wr_en       = bus.pix_valid && (bus.pix_x < XW'(LINE_W));
    assign line_done   = wr_en && (bus.pix_x == XW'(LINE_W - 1));
    assign wr_addr     = {wbank_q, bus.pix_x[AW-1:0]};
    assign rd_in_range = bus.rd_x < XW'(LINE_W);
    assign rd_addr     = {~wbank_q, bus.rd_x[AW-1:0]};

    // Next-state logic for the read-bank FSM, bank select and line metadata
    always_comb begin
        state_d    = state_q;
        wbank_d    = wbank_q;
        line_y_d   = line_y_q;
        overflow_d = overflow_q;
        // x==0 starts a line; use the fresh y so a swap in the same cycle sees it
        cap_y_d    = (wr_en && bus.pix_x == '0) ? bus.pix_y : cap_y_q;
        unique case (state_q)
            FREE: begin
                if (line_done) begin
                    state_d  = HELD;
                    wbank_d  = ~wbank_q;
                    line_y_d = cap_y_d;
                end
            end
            HELD: begin
                if (bus.line_ack && line_done) begin
                    // Ack frees the bank first, so the new line swaps straight in
                    wbank_d  = ~wbank_q;
                    line_y_d = cap_y_d;
                end else if (bus.line_ack) begin
                    state_d = FREE;
                end else if (line_done) begin
                    // Read bank still busy: drop the line, keep writing the same bank
                    overflow_d = 1'b1;
                end
            end
            default: state_d = FREE;
        endcase
    end

    // State and metadata registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FREE;
            wbank_q    <= 1'b0;
            line_y_q   <= '0;
            cap_y_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wbank_q    <= wbank_d;
            line_y_q   <= line_y_d;
            cap_y_q    <= cap_y_d;
            overflow_q <= overflow_d;
        end
    end

    // Pixel capture into the write bank; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= bus.pix_data;
        end
    end

    // Registered read port; uses the pre-swap bank select of the request cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_req;
            if (bus.rd_req) begin
                rd_data_q <= (state_q == HELD && rd_in_range) ? mem_q[rd_addr] : '0;
            end
        end
    end

    assign bus.line_ready = (state_q == HELD);
    assign bus.line_y     = line_y_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.overflow   = overflow_q;
    assign dbg_held_o     = (state_q == HELD);
endmodule

// File: tb/tb_ppu_scanline_buffer.sv
// Directed bench for ppu_scanline_buffer with a read-data scoreboard.
module tb_ppu_scanline_buffer;
    logic clk;
    logic reset;
    logic dbg_held;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic req_seen = 1'b0;

    ppu_scanline_buffer_if #(.XW(9), .PIX_W(8)) bus ();

    ppu_scanline_buffer #(.LINE_W(256), .PIX_W(8), .XW(9)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .dbg_held_o (dbg_held)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: a read request accepted at a posedge must answer one cycle later
    always @(posedge clk) req_seen <= bus.rd_req && !reset;

    always @(negedge clk) begin
        logic [7:0] e;
        if (req_seen || bus.rd_valid) begin
            check("rd_valid", {31'd0, bus.rd_valid}, {31'd0, req_seen});
        end
        if (req_seen && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rd_data", {24'd0, bus.rd_data}, {24'd0, e});
        end
    end

    // driver tasks (inputs change on the falling edge)
    task automatic pix_line(input int y, input int x0, input int x1,
                            input logic [7:0] key, input bit ack_last);
        for (int x = x0; x <= x1; x++) begin
            bus.pix_valid = 1'b1;
            bus.pix_x     = 9'(x);
            bus.pix_y     = 9'(y);
            bus.pix_data  = 8'(x) ^ key;
            bus.line_ack  = ack_last && (x == x1);
            @(negedge clk);
        end
        bus.pix_valid = 1'b0;
        bus.line_ack  = 1'b0;
    endtask

    task automatic read_one(input int x, input logic [7:0] e);
        bus.rd_req = 1'b1;
        bus.rd_x   = 9'(x);
        exp_q.push_back(e);
        @(negedge clk);
        bus.rd_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_line(input logic [7:0] key);
        for (int x = 0; x < 256; x++) begin
            bus.rd_req = 1'b1;
            bus.rd_x   = 9'(x);
            exp_q.push_back(8'(x) ^ key);
            @(negedge clk);
        end
        bus.rd_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic ack();
        bus.line_ack = 1'b1;
        @(negedge clk);
        bus.line_ack = 1'b0;
    endtask

    initial begin
        logic [7:0] k8, k9, k3, k4, k5, k2, k3b, k20, k21;
        k8  = 8'($urandom_range(0, 255));
        k9  = 8'($urandom_range(0, 255));
        k3  = 8'($urandom_range(0, 255));
        k4  = 8'($urandom_range(0, 255));
        k5  = 8'($urandom_range(0, 255));
        k2  = 8'($urandom_range(0, 255));
        k3b = 8'($urandom_range(0, 255));
        k20 = 8'($urandom_range(0, 255));
        k21 = 8'($urandom_range(0, 255));

        reset = 1'b1;
        bus.pix_valid = 1'b0;
        bus.pix_x = '0;
        bus.pix_y = '0;
        bus.pix_data = '0;
        bus.line_ack = 1'b0;
        bus.rd_req = 1'b0;
        bus.rd_x = '0;
        repeat (3) @(negedge clk);
        check("rst_line_ready", {31'd0, bus.line_ready}, 0);
        check("rst_line_y", {23'd0, bus.line_y}, 0);
        check("rst_rd_valid", {31'd0, bus.rd_valid}, 0);
        check("rst_rd_data", {24'd0, bus.rd_data}, 0);
        check("rst_overflow", {31'd0, bus.overflow}, 0);
        reset = 1'b0;
        @(negedge clk);

        // reads with no line held return zero
        read_one(5, 8'h00);
        read_one(300, 8'h00);

        // full line y=17, offered exactly one cycle after x=255
        pix_line(17, 0, 254, 8'hA5, 1'b0);
        check("t1_not_ready_at_254", {31'd0, bus.line_ready}, 0);
        pix_line(17, 255, 255, 8'hA5, 1'b0);
        check("t1_ready", {31'd0, bus.line_ready}, 1);
        check("t1_line_y", {23'd0, bus.line_y}, 17);
        read_line(8'hA5);

        // out-of-range reads and the last column
        read_one(300, 8'h00);
        read_one(256, 8'h00);
        read_one(255, 8'hFF ^ 8'hA5);

        ack();
        check("ack_frees", {31'd0, bus.line_ready}, 0);
        ack();
        check("ack_while_free", {31'd0, bus.line_ready}, 0);

        // ack coinciding with completion of the next line
        pix_line(8, 0, 255, k8, 1'b0);
        check("t3_y8", {23'd0, bus.line_y}, 8);
        pix_line(9, 0, 255, k9, 1'b1);
        check("t3_ready", {31'd0, bus.line_ready}, 1);
        check("t3_line_y", {23'd0, bus.line_y}, 9);
        check("t3_overflow", {31'd0, bus.overflow}, 0);
        read_line(k9);
        ack();

        // dropped line while held
        pix_line(3, 0, 255, k3, 1'b0);
        check("t2_y3", {23'd0, bus.line_y}, 3);
        pix_line(4, 0, 255, k4, 1'b0);
        check("t2_overflow", {31'd0, bus.overflow}, 1);
        check("t2_line_y_kept", {23'd0, bus.line_y}, 3);
        check("t2_ready_kept", {31'd0, bus.line_ready}, 1);
        read_line(k3);
        ack();
        check("t2_ack", {31'd0, bus.line_ready}, 0);
        pix_line(5, 0, 255, k5, 1'b0);
        check("t2_y5", {23'd0, bus.line_y}, 5);
        read_line(k5);
        ack();

        // partial line is never offered and is overwritten
        pix_line(2, 0, 100, k2, 1'b0);
        check("t5_partial_not_ready", {31'd0, bus.line_ready}, 0);
        pix_line(3, 0, 255, k3b, 1'b0);
        check("t5_ready", {31'd0, bus.line_ready}, 1);
        check("t5_line_y", {23'd0, bus.line_y}, 3);
        check("t5_overflow_sticky", {31'd0, bus.overflow}, 1);
        read_line(k3b);

        // reset while held with pixels streaming
        pix_line(20, 0, 50, k20, 1'b0);
        reset = 1'b1;
        bus.pix_valid = 1'b1;
        bus.pix_x = 9'd51;
        bus.pix_y = 9'd20;
        bus.pix_data = 8'd51 ^ k20;
        bus.rd_req = 1'b1;
        bus.rd_x = 9'd7;
        @(negedge clk);
        check("t6_ready", {31'd0, bus.line_ready}, 0);
        check("t6_overflow", {31'd0, bus.overflow}, 0);
        check("t6_rd_valid", {31'd0, bus.rd_valid}, 0);
        check("t6_line_y", {23'd0, bus.line_y}, 0);
        reset = 1'b0;
        bus.pix_valid = 1'b0;
        bus.rd_req = 1'b0;
        @(negedge clk);
        check("t6_idle_after_reset", {31'd0, bus.line_ready}, 0);
        pix_line(21, 0, 255, k21, 1'b0);
        check("t6_new_ready", {31'd0, bus.line_ready}, 1);
        check("t6_new_line_y", {23'd0, bus.line_y}, 21);
        check("t6_new_overflow", {31'd0, bus.overflow}, 0);
        read_line(k21);

        repeat (2) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
